// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS CPU <-> Memory bus blocks.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;

  // Run state of the bus write checker
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exp_table.sv
// Expected-entry table: DEPTH x (data, address), one write port, async read.
//  CLK            clock
//  wr_en          write strobe (out-of-range indices are dropped)
//  wr_idx         write index
//  wr_data        expected data to store
//  wr_addr        expected address to store
//  rd_idx         read index
//  rd_data_c      expected data at rd_idx (0 when out of range)
//  rd_addr_c      expected address at rd_idx (0 when out of range)
module exp_table
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data_c,
  output logic [ADDR_W-1:0] rd_addr_c
);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];

  // Contents survive reset so a table can be reused across runs
  always_ff @(posedge CLK) begin
    if (wr_en && (wr_idx < IDX_W'(DEPTH))) begin
      mem_data[wr_idx] <= wr_data;
      mem_addr[wr_idx] <= wr_addr;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_addr_c = '0;
    if (rd_idx < IDX_W'(DEPTH)) begin
      rd_data_c = mem_data[rd_idx];
      rd_addr_c = mem_addr[rd_idx];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Passive monitor on the CPU/Memory bus: checks each CPU write against a table of
// expected entries and reports pass/fail, counters and the first failure.
//  CLK, rst                        clock, synchronous active-high reset
//  start                           arm a new run (ignored while busy)
//  cs, we, addr, data              observed memory bus
//  exp_wr, exp_idx, exp_data/addr  expected-table write port (dropped while busy)
//  busy, done, pass, timeout       run status
//  check_cnt, err_cnt              writes checked / mismatches this run
//  err_valid, err_idx, err_got/exp first mismatch capture
module mem_write_checker
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned IDX_W      = 4,
  parameter bit          CHECK_ADDR = 1'b0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              exp_wr,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W-1:0] exp_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W-1:0]  check_cnt,
  output logic [IDX_W-1:0]  err_cnt,
  output logic              err_valid,
  output logic [IDX_W-1:0]  err_idx,
  output logic [DATA_W-1:0] err_got,
  output logic [DATA_W-1:0] err_exp
);

  localparam int unsigned WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t            state, state_nxt;
  logic              we_q;
  logic              wr_evt;
  logic              start_run, do_check, finish_ok, wd_expire;
  logic              mismatch;
  logic [WD_W-1:0]   wd_cnt;
  logic [DATA_W-1:0] tbl_data;
  logic [ADDR_W-1:0] tbl_addr;

  exp_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_exp_table (
    .CLK       (CLK),
    .wr_en     (exp_wr && !busy),
    .wr_idx    (exp_idx),
    .wr_data   (exp_data),
    .wr_addr   (exp_addr),
    .rd_idx    (check_cnt),
    .rd_data_c (tbl_data),
    .rd_addr_c (tbl_addr)
  );

  // Rising edge of the write strobe; a held strobe counts once
  assign wr_evt   = cs && we && !we_q;
  assign mismatch = (data != tbl_data) || (CHECK_ADDR && (addr != tbl_addr));

  // State register
  always_ff @(posedge CLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    do_check  = 1'b0;
    finish_ok = 1'b0;
    wd_expire = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        // A write on the watchdog expiry cycle still gets checked
        if (wr_evt) begin
          do_check = 1'b1;
          if (check_cnt == IDX_W'(DEPTH - 1)) begin
            finish_ok = 1'b1;
            state_nxt = S_DONE;
          end
        end else if ((TIMEOUT != 0) && (wd_cnt == WD_W'(WD_LAST))) begin
          wd_expire = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobe history, counters, watchdog and first-error capture
  always_ff @(posedge CLK) begin
    if (rst) begin
      we_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      check_cnt <= '0;
      err_cnt   <= '0;
      err_valid <= 1'b0;
      err_idx   <= '0;
      err_got   <= '0;
      err_exp   <= '0;
      wd_cnt    <= '0;
    end else begin
      we_q <= cs && we;
      busy <= (state_nxt == S_RUN);
      if (start_run) begin
        done      <= 1'b0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
        check_cnt <= '0;
        err_cnt   <= '0;
        err_valid <= 1'b0;
        err_idx   <= '0;
        err_got   <= '0;
        err_exp   <= '0;
        wd_cnt    <= '0;
      end
      if (do_check) begin
        check_cnt <= check_cnt + IDX_W'(1);
        wd_cnt    <= '0;
        if (mismatch) begin
          if (err_cnt != {IDX_W{1'b1}}) err_cnt <= err_cnt + IDX_W'(1);
          if (!err_valid) begin
            err_valid <= 1'b1;
            err_idx   <= check_cnt;
            err_got   <= data;
            err_exp   <= tbl_data;
          end
        end
      end else if ((state == S_RUN) && !wd_expire) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (finish_ok) begin
        done <= 1'b1;
        pass <= (err_cnt == '0) && !mismatch;
      end
      if (wd_expire) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Randomized self-checking bench for mem_write_checker against a transaction-level model.
module tb_mem_write_checker;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DEPTH   = 10;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cs = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data = '0;
  logic              exp_wr = 1'b0;
  logic [IDX_W-1:0]  exp_idx = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              busy, done, pass, timeout, err_valid;
  logic [IDX_W-1:0]  check_cnt, err_cnt, err_idx;
  logic [DATA_W-1:0] err_got, err_exp;

  mem_write_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .CHECK_ADDR(1'b1), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(clk), .rst(rst), .start(start), .cs(cs), .we(we), .addr(addr), .data(data),
    .exp_wr(exp_wr), .exp_idx(exp_idx), .exp_data(exp_data), .exp_addr(exp_addr),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .check_cnt(check_cnt), .err_cnt(err_cnt), .err_valid(err_valid),
    .err_idx(err_idx), .err_got(err_got), .err_exp(err_exp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: expected table plus the list of writes accepted in the current run
  logic [31:0] tbl_d [DEPTH];
  logic [31:0] tbl_a [DEPTH];
  logic [31:0] q_got [$];
  logic [31:0] q_exp [$];
  bit          q_bad [$];
  bit          run_active = 1'b0;
  bit          timed_out  = 1'b0;

  function automatic bit m_done();
    return (q_got.size() == DEPTH) || timed_out;
  endfunction

  function automatic bit m_busy();
    return run_active && !m_done();
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int          errs  = 0;
    int          first = 0;
    logic [31:0] g = '0;
    logic [31:0] e = '0;
    bit          pass_e;
    for (int i = 0; i < q_got.size(); i++) begin
      if (q_bad[i]) begin
        if (errs == 0) begin
          first = i;
          g = q_got[i];
          e = q_exp[i];
        end
        errs++;
      end
    end
    pass_e = run_active && (q_got.size() == DEPTH) && !timed_out && (errs == 0);
    check_eq({tag, ".busy"},      64'(busy),      64'(m_busy()));
    check_eq({tag, ".done"},      64'(done),      64'(run_active && m_done()));
    check_eq({tag, ".pass"},      64'(pass),      64'(pass_e));
    check_eq({tag, ".timeout"},   64'(timeout),   64'(timed_out));
    check_eq({tag, ".check_cnt"}, 64'(check_cnt), 64'(q_got.size()));
    check_eq({tag, ".err_cnt"},   64'(err_cnt),   64'(errs));
    check_eq({tag, ".err_valid"}, 64'(err_valid), 64'(errs != 0));
    check_eq({tag, ".err_idx"},   64'(err_idx),   64'(first));
    check_eq({tag, ".err_got"},   64'(err_got),   64'(g));
    check_eq({tag, ".err_exp"},   64'(err_exp),   64'(e));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_run();
    q_got.delete();
    q_exp.delete();
    q_bad.delete();
    timed_out = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_active = 1'b0;
    clear_run();
  endtask

  task automatic load_entry(input int idx, input logic [31:0] d, input logic [31:0] a);
    exp_wr = 1'b1; exp_idx = IDX_W'(idx); exp_data = d; exp_addr = a;
    if (!m_busy() && idx < DEPTH) begin
      tbl_d[idx] = d;
      tbl_a[idx] = a;
    end
    tick();
    exp_wr = 1'b0;
  endtask

  // Start pulse, optionally with a bus strobe and/or a table write in the same cycle
  task automatic pulse_start(input bit strobe, input bit ld, input int idx,
                             input logic [31:0] d, input logic [31:0] a);
    bit was_busy = m_busy();
    start = 1'b1;
    if (strobe) begin
      cs = 1'b1; we = 1'b1; data = $urandom; addr = $urandom;
    end
    if (ld) begin
      exp_wr = 1'b1; exp_idx = IDX_W'(idx); exp_data = d; exp_addr = a;
    end
    tick();
    start = 1'b0; cs = 1'b0; we = 1'b0; exp_wr = 1'b0;
    if (!was_busy) begin
      if (ld && idx < DEPTH) begin
        tbl_d[idx] = d;
        tbl_a[idx] = a;
      end
      run_active = 1'b1;
      clear_run();
    end
    tick();
  endtask

  task automatic bus_write(input logic [31:0] d, input logic [31:0] a, input int hold, input int gap);
    cs = 1'b1; we = 1'b1; data = d; addr = a;
    if (m_busy()) begin
      int k = q_got.size();
      q_got.push_back(d);
      q_exp.push_back(tbl_d[k]);
      q_bad.push_back((d != tbl_d[k]) || (a != tbl_a[k]));
    end
    repeat (hold) tick();
    cs = 1'b0; we = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic load_reference();
    logic [31:0] vals [DEPTH] = '{32'h6, 32'h12, 32'h18, 32'hC, 32'h2,
                                  32'h16, 32'h1, 32'h120, 32'h3, 32'h00412022};
    for (int i = 0; i < DEPTH; i++) load_entry(i, vals[i], 32'h1000 + 32'(4 * i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    do_reset();
    check_outputs("reset");

    // 1: all writes match
    load_reference();
    load_entry(12, 32'hDEAD, 32'hBEEF);
    pulse_start(1'b1, 1'b0, 0, 0, 0);
    check_outputs("t1_start");
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(tbl_d[i], tbl_a[i], 1, 1);
      check_outputs("t1_wr");
    end
    bus_write(32'h55, 32'h0, 1, 1);
    check_outputs("t1_after_done");

    // 2: data mismatch on write #3
    pulse_start(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus_write((i == 2) ? 32'h19 : tbl_d[i], tbl_a[i], 1, 2);
      check_outputs("t2_wr");
    end
    check_eq("t2_err_got", 64'(err_got), 64'h19);
    check_eq("t2_err_exp", 64'(err_exp), 64'h18);

    // 3: address-only mismatch on write #5
    pulse_start(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(tbl_d[i], (i == 4) ? 32'h7777 : tbl_a[i], 1, 1);
      check_outputs("t3_wr");
    end
    check_eq("t3_err_idx", 64'(err_idx), 64'd4);

    // 4: watchdog after 4 writes
    pulse_start(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) bus_write(tbl_d[i], tbl_a[i], 1, 1);
    repeat (TIMEOUT - 2) tick();
    check_outputs("t4_before_expiry");
    tick();
    timed_out = 1'b1;
    check_outputs("t4_expiry");
    check_eq("t4_timeout", 64'(timeout), 64'd1);

    // 5: held strobe, start and table write while running, start+load same cycle
    pulse_start(1'b0, 1'b1, 0, 32'hABCD0000, tbl_a[0]);
    bus_write(32'hABCD0000, tbl_a[0], 5, 1);
    check_outputs("t5_held");
    pulse_start(1'b0, 1'b0, 0, 0, 0);
    check_outputs("t5_start_ignored");
    load_entry(1, 32'hFFFF_FFFF, 32'h0);
    for (int i = 1; i < DEPTH; i++) begin
      bus_write(tbl_d[i], tbl_a[i], 1, 1);
      check_outputs("t5_wr");
    end

    // 6: reset mid-run, then a clean run from the retained table
    pulse_start(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 6; i++) bus_write(tbl_d[i], (i == 1) ? 32'h1 : tbl_a[i], 1, 1);
    check_outputs("t6_partial");
    do_reset();
    check_outputs("t6_reset");
    pulse_start(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(tbl_d[i], tbl_a[i], 1, 1);
      check_outputs("t6_wr");
    end

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) load_entry(i, $urandom, $urandom);
      pulse_start(1'($urandom_range(0, 1)), 1'b0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
        logic [31:0] d = tbl_d[i];
        logic [31:0] a = tbl_a[i];
        int sel = $urandom_range(0, 7);
        if (sel == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
        if (sel == 1) a = a ^ (32'h1 << $urandom_range(0, 31));
        if (sel == 2) load_entry($urandom_range(0, DEPTH - 1), $urandom, $urandom);
        if (sel == 3) pulse_start(1'b0, 1'b0, 0, 0, 0);
        bus_write(d, a, $urandom_range(1, 3), $urandom_range(1, 3));
        check_outputs("rnd_wr");
      end
      bus_write($urandom, $urandom, 1, 1);
      check_outputs("rnd_done");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
